// File: rtl/double_dabble.sv
// ============================================================================
// Module  : double_dabble
// Purpose : Sequential binary-to-BCD converter (shift-add-3), one shift per clock.
//           Build option DOUBLE_DABBLE_ONESHOT_EN parks the FSM in DONE after
//           the first conversion; undefined gives a free-running converter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module double_dabble #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nx;
  logic [4*DIGITS-1:0]  digits;
  logic [4*DIGITS-1:0]  digits_adj;
  logic [WIDTH-1:0]     bits;
  logic [CNT_W-1:0]     count;
  logic                 last_shift;

  assign last_shift = (count == CNT_W'(WIDTH - 1));

  // Add-3 correction wraps modulo 16; digit sizing keeps the top digit in range.
  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    assign digits_adj[4*k +: 4] = (digits[4*k +: 4] >= 4'd5) ?
                                  (digits[4*k +: 4] + 4'd3) : digits[4*k +: 4];
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= LOAD;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      LOAD:    state_nx = SHIFT;
      SHIFT:   if (last_shift) state_nx = DONE;
`ifdef DOUBLE_DABBLE_ONESHOT_EN
      DONE:    state_nx = DONE;
`else
      DONE:    state_nx = LOAD;
`endif
      default: state_nx = LOAD;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      bcd    <= '0;
      done   <= 1'b0;
      digits <= '0;
      bits   <= '0;
      count  <= '0;
    end else begin
      case (state)
        LOAD: begin
          bits   <= bin;
          digits <= '0;
          count  <= '0;
          done   <= 1'b0;
        end
        SHIFT: begin
          {digits, bits} <= {digits_adj[4*DIGITS-2:0], bits, 1'b0};
          count          <= count + CNT_W'(1);
        end
        DONE: begin
          bcd  <= digits;
          done <= 1'b1;
        end
        default: begin
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_double_dabble.sv
// ============================================================================
// Module  : tb_double_dabble
// Purpose : Randomised self-checking bench for double_dabble against a
//           divide-by-ten reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_double_dabble;

  logic        clock;
  logic        reset;
  logic [31:0] bin;
  logic [39:0] bcd;
  logic        done;

  int tests;
  int fails;

  double_dabble #(32) dut (
    .clock (clock),
    .reset (reset),
    .bin   (bin),
    .bcd   (bcd),
    .done  (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [39:0] to_bcd(input longint unsigned v);
    logic [39:0] r;
    longint unsigned t;
    r = '0;
    t = v;
    for (int k = 0; k < 10; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Ticks until done rises (bounded); reports edges taken and whether bcd held.
  task automatic wait_done(input logic [39:0] hold, output int cycles, output bit held);
    cycles = 0;
    held   = 1'b1;
    while (cycles < 40) begin
      tick();
      cycles++;
      if (done === 1'b1) break;
      if (bcd !== hold || done !== 1'b0) held = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bin   = $urandom;
    repeat (3) tick();
    tests++;
    if (bcd !== 40'h0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset: bcd=%h done=%b, required bcd=0 done=0", bcd, done);
    end
  endtask

  task automatic test_first_conversion();
    int  cyc;
    bit  held;
    bin   = 32'd2;
    reset = 1'b1;
    wait_done(40'h0, cyc, held);
    tests++;
    if (cyc !== 34) begin
      fails++;
      $display("FAIL first_latency: %0d edges, required 34", cyc);
    end
    tests++;
    if (!held) begin
      fails++;
      $display("FAIL first_hold: bcd/done changed before completion, required bcd=0 done=0");
    end
    tests++;
    if (bcd !== 40'h0000000002) begin
      fails++;
      $display("FAIL first_value: bcd=%h, required 0000000002", bcd);
    end
    wait_done(40'h0000000002, cyc, held);
    tests++;
    if (cyc !== 34 || !held) begin
      fails++;
      $display("FAIL period: %0d edges held=%0d, required 34 held=1", cyc, held);
    end
    tests++;
    if (bcd !== 40'h0000000002) begin
      fails++;
      $display("FAIL repeat_value: bcd=%h, required 0000000002", bcd);
    end
    tick();
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL done_width: done=%b one cycle after pulse, required 0", done);
    end
  endtask

  // Assumes the caller sits just after a done pulse (state LOAD on next edge).
  task automatic test_values();
    logic [31:0] vals[$];
    logic [39:0] prev;
    int  cyc;
    bit  held;
    wait_done(bcd, cyc, held);
    vals = '{32'd0, 32'hFFFF_FFFF, 32'd99999, 32'd9, 32'd10};
    for (int i = 0; i < 8; i++) vals.push_back($urandom);
    for (int i = 0; i < 4; i++) vals.push_back($urandom_range(0, 9999));
    foreach (vals[i]) begin
      prev = bcd;
      bin  = vals[i];
      wait_done(prev, cyc, held);
      tests++;
      if (cyc !== 34 || !held) begin
        fails++;
        $display("FAIL value_timing[%0d]: %0d edges held=%0d, required 34 held=1", i, cyc, held);
      end
      tests++;
      if (bcd !== to_bcd(longint'(vals[i]))) begin
        fails++;
        $display("FAIL value[%0d] bin=%0d: bcd=%h, required %h", i, vals[i], bcd, to_bcd(longint'(vals[i])));
      end
    end
  endtask

  task automatic test_bin_change();
    int cyc;
    bit held;
    bin = 32'd12345;
    repeat (10) tick();
    bin = 32'd7;
    wait_done(bcd, cyc, held);
    tests++;
    if (bcd !== 40'h0000012345 || cyc !== 24) begin
      fails++;
      $display("FAIL bin_change_pass1: bcd=%h after %0d edges, required 0000012345 after 24", bcd, cyc);
    end
    wait_done(40'h0000012345, cyc, held);
    tests++;
    if (bcd !== 40'h0000000007 || cyc !== 34 || !held) begin
      fails++;
      $display("FAIL bin_change_pass2: bcd=%h edges=%0d held=%0d, required 0000000007 34 1", bcd, cyc, held);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    int cyc;
    bit held;
    v   = $urandom;
    bin = v;
    repeat (20) tick();
    reset = 1'b0;
    tick();
    tests++;
    if (bcd !== 40'h0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: bcd=%h done=%b, required bcd=0 done=0", bcd, done);
    end
    reset = 1'b1;
    wait_done(40'h0, cyc, held);
    tests++;
    if (cyc !== 34 || !held || bcd !== to_bcd(longint'(v))) begin
      fails++;
      $display("FAIL reset_restart: bcd=%h edges=%0d held=%0d, required %h 34 1", bcd, cyc, held, to_bcd(longint'(v)));
    end
  endtask

  task automatic test_oneshot();
    int cyc;
    bit held;
    bit stuck;
    reset = 1'b0;
    tick();
    bin   = 32'd255;
    reset = 1'b1;
    wait_done(40'h0, cyc, held);
    tests++;
    if (cyc !== 34 || bcd !== 40'h0000000255) begin
      fails++;
      $display("FAIL oneshot_value: bcd=%h edges=%0d, required 0000000255 34", bcd, cyc);
    end
    bin   = 32'd1000;
    stuck = 1'b1;
    repeat (80) begin
      tick();
      if (done !== 1'b1 || bcd !== 40'h0000000255) stuck = 1'b0;
    end
    tests++;
    if (!stuck) begin
      fails++;
      $display("FAIL oneshot_park: bcd=%h done=%b, required 0000000255 and 1", bcd, done);
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    wait_done(40'h0, cyc, held);
    tests++;
    if (cyc !== 34 || bcd !== 40'h0000001000) begin
      fails++;
      $display("FAIL oneshot_restart: bcd=%h edges=%0d, required 0000001000 34", bcd, cyc);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b0;
    bin   = '0;
    test_reset();
`ifdef DOUBLE_DABBLE_ONESHOT_EN
    test_oneshot();
`else
    test_first_conversion();
    test_values();
    test_bin_change();
    test_reset_mid();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
